// File: rtl/key_pkg.sv
// Shared definitions for the key-gesture transmitter and the detector side:
// FSM state type, default timing constants and the bounce LFSR step.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BNC_DN,
    ST_HOLD,
    ST_BNC_UP,
    ST_GAP,
    ST_COOL
  } key_state_e;

  // Reference clock and detector-side timing (50 MHz).
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DET_DEBOUNCE_CYC  = 1_000_000;   // 20 ms debounce
  localparam int unsigned DET_CLICK_WIN_CYC = 30_000_000;  // 600 ms click window

  // Default gesture timing. BOUNCE stays below the detector debounce and
  // COOL exceeds the click window, so each gesture is reported on its own.
  localparam int unsigned DEF_PRESS_CYC   = 5_000_000;
  localparam int unsigned DEF_LONG_CYC    = 75_000_000;
  localparam int unsigned DEF_GAP_CYC     = 10_000_000;
  localparam int unsigned DEF_BOUNCE_CYC  = 250_000;
  localparam int unsigned DEF_BOUNCE_STEP = 12_500;
  localparam int unsigned DEF_COOL_CYC    = 35_000_000;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_bounce_lfsr.sv
// 16-bit Galois LFSR producing the pseudo-random contact-bounce bit.
// Advances only when en is high; restarts from seed on reset.
module key_bounce_lfsr
  import key_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic        bit_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: hold unless stepping.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[0];

endmodule

// File: rtl/key_press_gen.sv
// Key-gesture transmitter: emits N bouncy active-low presses (optionally long),
// separated by gaps and followed by a cooldown, then pulses done.
module key_press_gen
  import key_pkg::*;
#(
  parameter int unsigned PRESS_CYC   = DEF_PRESS_CYC,
  parameter int unsigned LONG_CYC    = DEF_LONG_CYC,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
  parameter int unsigned BOUNCE_CYC  = DEF_BOUNCE_CYC,
  parameter int unsigned BOUNCE_STEP = DEF_BOUNCE_STEP,
  parameter int unsigned COOL_CYC    = DEF_COOL_CYC,
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_count,
  input  logic       cmd_long,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_CYC =
    max2(max2(max2(PRESS_CYC, LONG_CYC), max2(GAP_CYC, BOUNCE_CYC)), COOL_CYC);
  localparam int unsigned TW = $clog2(MAX_CYC) + 1;
  localparam int unsigned SW = $clog2(BOUNCE_STEP + 1);

  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_PRESS  = TW'(PRESS_CYC);
  localparam logic [TW-1:0] T_LONG   = TW'(LONG_CYC);
  localparam logic [TW-1:0] T_GAP    = TW'(GAP_CYC);
  localparam logic [TW-1:0] T_BOUNCE = TW'(BOUNCE_CYC);
  localparam logic [TW-1:0] T_COOL   = TW'(COOL_CYC);
  localparam logic [SW-1:0] S_LAST   = SW'(BOUNCE_STEP - 1);

  key_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    presses_q, presses_d;
  logic          long_q, long_d;
  logic [SW-1:0] step_q, step_d;

  logic expire;
  logic in_bounce;
  logic lfsr_en;
  logic lfsr_bit;

  assign expire    = (timer_q == T_ONE);
  assign in_bounce = (state_q == ST_BNC_DN) || (state_q == ST_BNC_UP);

  key_bounce_lfsr u_lfsr (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .en      (lfsr_en),
    .seed    (LFSR_SEED),
    .bit_out (lfsr_bit)
  );

  // Bounce sample pacing: the step counter restarts on every bounce window
  // because it is cleared in all non-bounce states.
  always_comb begin
    lfsr_en = in_bounce && (step_q == S_LAST);
    step_d  = '0;
    if (in_bounce && !lfsr_en) begin
      step_d = step_q + SW'(1);
    end
  end

  // Gesture FSM: next state, timer reload/decrement and output decode.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    presses_d = presses_q;
    long_d    = long_q;
    key_out   = 1'b1;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    if (state_q != ST_IDLE) begin
      timer_d = timer_q - T_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          presses_d = cmd_count;
          long_d    = cmd_long;
          if (cmd_count == 2'd0) begin
            state_d = ST_COOL;
            timer_d = T_COOL;
          end else begin
            state_d = ST_BNC_DN;
            timer_d = T_BOUNCE;
          end
        end
      end
      ST_BNC_DN: begin
        key_out = expire ? 1'b0 : lfsr_bit;
        if (expire) begin
          state_d = ST_HOLD;
          timer_d = long_q ? T_LONG : T_PRESS;
        end
      end
      ST_HOLD: begin
        key_out = 1'b0;
        if (expire) begin
          state_d   = ST_BNC_UP;
          timer_d   = T_BOUNCE;
          presses_d = presses_q - 2'd1;
        end
      end
      ST_BNC_UP: begin
        key_out = expire ? 1'b1 : lfsr_bit;
        if (expire) begin
          if (presses_q != 2'd0) begin
            state_d = ST_GAP;
            timer_d = T_GAP;
          end else begin
            state_d = ST_COOL;
            timer_d = T_COOL;
          end
        end
      end
      ST_GAP: begin
        if (expire) begin
          state_d = ST_BNC_DN;
          timer_d = T_BOUNCE;
        end
      end
      ST_COOL: begin
        if (expire) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Abort overrides any expiry decided above; it is a no-op in IDLE/COOL.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_COOL)) begin
      state_d   = ST_COOL;
      timer_d   = T_COOL;
      presses_d = '0;
    end
  end

  // State, timer and command registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      presses_q <= '0;
      long_q    <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      presses_q <= presses_d;
      long_q    <= long_d;
      step_q    <= step_d;
    end
  end

endmodule
